// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO read arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_e;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned IDX_WIDTH = $clog2(MAX_PORTS);

  typedef struct packed {
    logic                 found;
    logic [IDX_WIDTH-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned src_width(input int unsigned nPorts);
    return (nPorts > 1) ? $clog2(nPorts) : 1;
  endfunction

  // First requesting index at or after ptr, wrapping modulo nPorts (any value 2..16).
  function automatic rr_pick_t next_rr_index(input logic [IDX_WIDTH-1:0] ptr,
                                             input logic [MAX_PORTS-1:0] req,
                                             input int unsigned          nPorts);
    rr_pick_t             pick;
    logic [IDX_WIDTH:0]   cand;
    logic [IDX_WIDTH:0]   limit;
    pick  = '0;
    limit = (IDX_WIDTH+1)'(nPorts);
    for (int k = MAX_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (cand >= limit) cand = cand - limit;
      if ((k < int'(nPorts)) && req[cand[IDX_WIDTH-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[IDX_WIDTH-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_out_buf.sv
// Two-entry {src, data} skid buffer presenting a valid/ready stream.
module arb_out_buf #(
  parameter int SRC_WIDTH  = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [SRC_WIDTH-1:0]  push_src_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [SRC_WIDTH-1:0]  src_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occ_o
);

  typedef struct packed {
    logic [SRC_WIDTH-1:0]  src;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t     mem_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] occ_q;
  logic       pop;
  logic       push;

  assign pop  = (occ_q != 2'd0) && ready_i;
  assign push = push_i && ((occ_q != 2'd2) || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= {push_src_i, push_data_i};
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      if (push && !pop) occ_q <= occ_q + 2'd1;
      else if (pop && !push) occ_q <= occ_q - 2'd1;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign src_o   = mem_q[rdPtr_q].src;
  assign data_o  = mem_q[rdPtr_q].data;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin, burst-capable read scheduler draining N FIFO read sides into one stream.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_PORTS    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int SRC_WIDTH  = src_width(N_PORTS),
  localparam int BW         = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_PORTS-1:0]            rempty,
  input  logic [N_PORTS*DATA_WIDTH-1:0] rdata,
  output logic [N_PORTS-1:0]            rden,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [SRC_WIDTH-1:0]          m_src
);

  arb_state_e                         state_q, state_d;
  logic [SRC_WIDTH-1:0]               ptr_q, ptr_d;
  logic [SRC_WIDTH-1:0]               grant_q, grant_d;
  logic [BW-1:0]                      burst_q, burst_d;
  logic                               inflight_q;
  logic [SRC_WIDTH-1:0]               inflightSrc_q;

  logic                               issue;
  logic [SRC_WIDTH-1:0]               issueIdx;
  logic [MAX_PORTS-1:0]               reqVec;
  rr_pick_t                           pick;
  logic [1:0]                         occ;
  logic                               pop;
  logic [2:0]                         committed;
  logic                               creditOk;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] rdataArr;
  logic [DATA_WIDTH-1:0]              pushData;

  function automatic logic [SRC_WIDTH-1:0] wrapInc(input logic [SRC_WIDTH-1:0] g);
    return (g == SRC_WIDTH'(N_PORTS - 1)) ? '0 : g + 1'b1;
  endfunction

  assign rdataArr = rdata;
  assign pushData = rdataArr[inflightSrc_q];
  assign pop      = m_valid && m_ready;

  // Credit counts the buffer level after this cycle's pop, so a full-rate stream keeps issuing.
  assign committed = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign creditOk  = (committed < 3'd2);

  always_comb begin
    reqVec              = '0;
    reqVec[N_PORTS-1:0] = ~rempty;
  end

  assign pick = next_rr_index(IDX_WIDTH'(ptr_q), reqVec, N_PORTS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      burst_q       <= '0;
      inflight_q    <= 1'b0;
      inflightSrc_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      burst_q       <= burst_d;
      inflight_q    <= issue;
      inflightSrc_q <= issueIdx;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    issue    = 1'b0;
    issueIdx = grant_q;
    case (state_q)
      IDLE: begin
        if (pick.found && creditOk) begin
          issue    = 1'b1;
          issueIdx = SRC_WIDTH'(pick.idx);
          grant_d  = SRC_WIDTH'(pick.idx);
          if (MAX_BURST == 1) begin
            ptr_d   = wrapInc(SRC_WIDTH'(pick.idx));
            burst_d = '0;
          end else begin
            burst_d = BW'(1);
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (rempty[grant_q]) begin
          state_d = IDLE;
          ptr_d   = wrapInc(grant_q);
          burst_d = '0;
        end else if (creditOk) begin
          issue = 1'b1;
          // The issue that reaches MAX_BURST also releases the grant.
          if (burst_q == BW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            ptr_d   = wrapInc(grant_q);
            burst_d = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rden = '0;
    if (issue && reset_n) rden[issueIdx] = 1'b1;
  end

  arb_out_buf #(
    .SRC_WIDTH (SRC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .push_i     (inflight_q),
    .push_src_i (inflightSrc_q),
    .push_data_i(pushData),
    .ready_i    (m_ready),
    .valid_o    (m_valid),
    .src_o      (m_src),
    .data_o     (m_data),
    .occ_o      (occ)
  );

endmodule
